cactus_spawner: RTL and testbench



---
 rtl/dino_pkg.sv | 22 ++
 rtl/lfsr16.sv | 29 ++
 rtl/cactus_spawner.sv | 183 ++++++++++++++++++
 tb/tb_cactus_spawner.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// dino_pkg: constants and types shared by the obstacle producer
// (cactus_spawner), the collision/jump logic and the renderer.
//   POS_W     width of one slot on the cactus position bus
//   N_CACTUS  number of obstacle slots on the bus
//   SCREEN_W / X_OFFSET  screen geometry used by the renderer
//   MAX_POS_DEF  default travel at which an obstacle is retired
//   state_t   spawner sequencing states
package dino_pkg;

  localparam int POS_W       = 12;
  localparam int N_CACTUS    = 4;
  localparam int SCREEN_W    = 1024;
  localparam int X_OFFSET    = 200;
  localparam int MAX_POS_DEF = 1274;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UPD   = 2'd1,
    SPAWN = 2'd2
  } state_t;

endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11 (right shift,
// toggle mask 16'hB400). Also intended for cactus-type selection.
//   clk      clock
//   reset    synchronous active-high reset, loads i_seed
//   i_en     advance one step
//   i_load   load i_seed (wins over i_en)
//   i_seed   seed value, must be non-zero
//   o_state  current LFSR state
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  always_ff @(posedge clk) begin
    if (reset || i_load)
      r_state <= i_seed;
    else if (i_en)
      r_state <= r_state[0] ? ((r_state >> 1) ^ 16'hB400) : (r_state >> 1);
  end

  assign o_state = r_state;

endmodule

// File: rtl/cactus_spawner.sv
// cactus_spawner: producer of the cactus position bus. Every TICK_DIV run
// cycles it scrolls the four slots (one slot per cycle, UPD), then makes one
// spawn decision (SPAWN). cactus_sync is high for those 5 cycles; slot
// values are final once it reads 0.
//   clk          clock
//   reset        synchronous active-high reset
//   run          1 = scrolling enabled, 0 = positions frozen
//   clear        one-cycle new-game pulse (priority below reset only)
//   cactuses0..3 slot positions (0 = empty, else travel since spawn)
//   cactus_sync  high while slots may be changing
// Build option: define SPEEDUP_EN to raise the scroll step by one every
// SPEEDUP_SPAWNS spawns, up to STEP_MAX. Without it the step is fixed.
module cactus_spawner
  import dino_pkg::*;
#(
  parameter int          TICK_DIV       = 390625,
  parameter int          STEP           = 4,
  parameter int          MAX_POS        = MAX_POS_DEF,
  parameter int          MIN_GAP        = 250,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          STEP_MAX       = 12,
  parameter int          SPEEDUP_SPAWNS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clear,
  output logic [POS_W-1:0] cactuses0,
  output logic [POS_W-1:0] cactuses1,
  output logic [POS_W-1:0] cactuses2,
  output logic [POS_W-1:0] cactuses3,
  output logic             cactus_sync
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = 16;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  state_t                          r_state, w_state_nx;
  logic [CNT_W-1:0]                r_tick, w_tick_nx;
  logic [1:0]                      r_k, w_k_nx;
  logic [N_CACTUS-1:0][POS_W-1:0]  r_slot, w_slot_nx;
  logic [GAP_W-1:0]                r_gap, w_gap_nx, w_gap_dec;
  logic [POS_W-1:0]                w_step;
  logic [POS_W-1:0]                w_cur;
  logic [POS_W:0]                  w_sum;
  logic [POS_W-1:0]                w_upd_val;
  logic [1:0]                      w_free_idx;
  logic                            w_free_vld;
  logic                            w_lfsr_en;
  logic                            w_spawned;
  logic [15:0]                     w_lfsr;
  logic                            w_lfsr_unused;

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_lfsr_en),
    .i_load  (clear),
    .i_seed  (LFSR_SEED),
    .o_state (w_lfsr)
  );

  // only the low byte feeds the gap
  assign w_lfsr_unused = ^w_lfsr[15:8];

  // 13-bit sum so a slot near the top of the 12-bit range cannot wrap
  assign w_cur = r_slot[r_k];
  assign w_sum = {1'b0, w_cur} + {1'b0, w_step};
  always_comb begin
    w_upd_val = w_sum[POS_W-1:0];
    if (w_cur == '0)
      w_upd_val = '0;
    else if (w_sum >= (POS_W+1)'(MAX_POS))
      w_upd_val = '0;
  end

  assign w_gap_dec = (r_gap > GAP_W'(w_step)) ? (r_gap - GAP_W'(w_step)) : '0;

  // lowest-index empty slot (scan high to low so the lowest wins)
  always_comb begin
    w_free_idx = '0;
    w_free_vld = 1'b0;
    for (int i = N_CACTUS - 1; i >= 0; i--) begin
      if (r_slot[i] == '0) begin
        w_free_idx = 2'(i);
        w_free_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_tick_nx  = r_tick;
    w_k_nx     = r_k;
    w_slot_nx  = r_slot;
    w_gap_nx   = r_gap;
    w_lfsr_en  = 1'b0;
    w_spawned  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (run) begin
          if (r_tick == TICK_LAST) begin
            w_tick_nx  = '0;
            w_k_nx     = '0;
            w_state_nx = UPD;
          end else begin
            w_tick_nx = r_tick + 1'b1;
          end
        end
      end
      UPD: begin
        w_slot_nx[r_k] = w_upd_val;
        w_k_nx         = r_k + 2'd1;
        if (r_k == 2'(N_CACTUS - 1))
          w_state_nx = SPAWN;
      end
      SPAWN: begin
        w_state_nx = IDLE;
        // with no free slot the gap sits at 0 and the spawn retries next tick
        if (w_gap_dec == '0 && w_free_vld) begin
          w_slot_nx[w_free_idx] = POS_W'(1);
          w_gap_nx              = GAP_W'(MIN_GAP) + {8'd0, w_lfsr[7:0]};
          w_lfsr_en             = 1'b1;
          w_spawned             = 1'b1;
        end else begin
          w_gap_nx = w_gap_dec;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_k     <= '0;
      r_slot  <= '0;
      r_gap   <= GAP_W'(MIN_GAP);
    end else begin
      r_state <= w_state_nx;
      r_tick  <= w_tick_nx;
      r_k     <= w_k_nx;
      r_slot  <= w_slot_nx;
      r_gap   <= w_gap_nx;
    end
  end

`ifdef SPEEDUP_EN
  logic [POS_W-1:0] r_step;
  logic [7:0]       r_spawn_cnt;

  // the new step is registered after SPAWN, so it applies from the next tick
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_step      <= POS_W'(STEP);
      r_spawn_cnt <= '0;
    end else if (w_spawned) begin
      if (r_spawn_cnt == 8'(SPEEDUP_SPAWNS - 1)) begin
        r_spawn_cnt <= '0;
        if (r_step < POS_W'(STEP_MAX))
          r_step <= r_step + 1'b1;
      end else begin
        r_spawn_cnt <= r_spawn_cnt + 1'b1;
      end
    end
  end

  assign w_step = r_step;
`else
  logic w_spawned_unused;
  assign w_spawned_unused = w_spawned;
  assign w_step           = POS_W'(STEP);
`endif

  assign cactuses0   = r_slot[0];
  assign cactuses1   = r_slot[1];
  assign cactuses2   = r_slot[2];
  assign cactuses3   = r_slot[3];
  assign cactus_sync = (r_state != IDLE);

endmodule

// File: tb/tb_cactus_spawner.sv
// Bench for cactus_spawner. Two instances share stimulus: d0 uses the short
// playfield (MAX_POS=40), d1 a long one (MAX_POS=1000) so all four slots fill
// and the spawn has to wait for a retire. A tick-level reference model applies
// each tick's whole update at once and publishes it when the 5-cycle sync
// window ends; slots are compared whenever sync is expected low.
module tb_cactus_spawner;

  localparam int TD   = 4;
  localparam int ST   = 4;
  localparam int MG   = 8;
  localparam int SMAX = 6;
  localparam int SSP  = 2;

  logic clk = 1'b0, reset = 1'b1, run = 1'b0, clear = 1'b0;
  logic [11:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic        as, bs;
  logic [11:0] o_pos [2][4];
  logic        o_sync [2];

  always #5 clk = ~clk;

  cactus_spawner #(.TICK_DIV(TD), .STEP(ST), .MAX_POS(40), .MIN_GAP(MG),
    .LFSR_SEED(16'hACE1), .STEP_MAX(SMAX), .SPEEDUP_SPAWNS(SSP)) dut0 (
    .clk(clk), .reset(reset), .run(run), .clear(clear),
    .cactuses0(a0), .cactuses1(a1), .cactuses2(a2), .cactuses3(a3),
    .cactus_sync(as));

  cactus_spawner #(.TICK_DIV(TD), .STEP(ST), .MAX_POS(1000), .MIN_GAP(MG),
    .LFSR_SEED(16'hACE1), .STEP_MAX(SMAX), .SPEEDUP_SPAWNS(SSP)) dut1 (
    .clk(clk), .reset(reset), .run(run), .clear(clear),
    .cactuses0(b0), .cactuses1(b1), .cactuses2(b2), .cactuses3(b3),
    .cactus_sync(bs));

  assign o_pos[0][0] = a0; assign o_pos[0][1] = a1;
  assign o_pos[0][2] = a2; assign o_pos[0][3] = a3;
  assign o_pos[1][0] = b0; assign o_pos[1][1] = b1;
  assign o_pos[1][2] = b2; assign o_pos[1][3] = b3;
  assign o_sync[0] = as;
  assign o_sync[1] = bs;

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
    end
  endtask

  // reference model state, per instance
  int m_slot [2][4], p_slot [2][4];
  int m_gap [2], m_lfsr [2], m_cnt [2], m_busy [2], m_step [2], m_sc [2];
  int p_gap [2], p_lfsr [2], p_step [2], p_sc [2];

  function automatic int maxp(input int d);
    return (d == 0) ? 40 : 1000;
  endfunction

  function automatic int nxt_lfsr(input int s);
    return (s & 1) ? ((s >> 1) ^ 'hB400) : (s >> 1);
  endfunction

  task automatic m_init(input int d);
    for (int k = 0; k < 4; k++) m_slot[d][k] = 0;
    m_gap[d] = MG; m_lfsr[d] = 'hACE1; m_cnt[d] = 0; m_busy[d] = 0;
    m_step[d] = ST; m_sc[d] = 0;
  endtask

  // whole-tick effect: scroll/retire every slot, then one spawn decision
  task automatic m_tick(input int d);
    int  s;
    bit  done;
    for (int k = 0; k < 4; k++) begin
      s = m_slot[d][k];
      if (s != 0) begin
        s = s + m_step[d];
        if (s >= maxp(d)) s = 0;
      end
      p_slot[d][k] = s;
    end
    p_gap[d]  = (m_gap[d] > m_step[d]) ? m_gap[d] - m_step[d] : 0;
    p_lfsr[d] = m_lfsr[d];
    p_step[d] = m_step[d];
    p_sc[d]   = m_sc[d];
    if (p_gap[d] == 0) begin
      done = 1'b0;
      for (int k = 0; k < 4; k++)
        if (!done && p_slot[d][k] == 0) begin
          p_slot[d][k] = 1;
          done = 1'b1;
        end
      if (done) begin
        p_gap[d]  = MG + (m_lfsr[d] & 255);
        p_lfsr[d] = nxt_lfsr(m_lfsr[d]);
`ifdef SPEEDUP_EN
        p_sc[d]++;
        if (p_sc[d] == SSP) begin
          p_sc[d] = 0;
          if (p_step[d] < SMAX) p_step[d]++;
        end
`endif
      end
    end
  endtask

  task automatic m_clk(input int d, input bit rs, input bit rn, input bit cl);
    if (rs || cl) m_init(d);
    else if (m_busy[d] > 0) begin
      m_busy[d]--;
      if (m_busy[d] == 0) begin
        for (int k = 0; k < 4; k++) m_slot[d][k] = p_slot[d][k];
        m_gap[d] = p_gap[d]; m_lfsr[d] = p_lfsr[d];
        m_step[d] = p_step[d]; m_sc[d] = p_sc[d];
      end
    end else if (rn) begin
      if (m_cnt[d] == TD - 1) begin
        m_cnt[d]  = 0;
        m_busy[d] = 5;
        m_tick(d);
      end else m_cnt[d]++;
    end
  endtask

  bit full_seen = 1'b0;

  // drive inputs for one cycle, advance model on the edge, compare 1ns later
  task automatic cyc(input bit rs, input bit rn, input bit cl);
    reset = rs; run = rn; clear = cl;
    @(posedge clk);
    for (int d = 0; d < 2; d++) m_clk(d, rs, rn, cl);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_sync", d), int'(o_sync[d]), int'(m_busy[d] > 0));
      if (m_busy[d] == 0)
        for (int k = 0; k < 4; k++)
          chk($sformatf("d%0d_slot%0d", d, k), int'(o_pos[d][k]), m_slot[d][k]);
    end
    if (b0 != 0 && b1 != 0 && b2 != 0 && b3 != 0 && !bs) full_seen = 1'b1;
  endtask

  // edges from now until slot 0 becomes non-zero (-1 on timeout)
  task automatic edges_to_spawn(output int n_spawn, output int n_sync);
    int n;
    n = 0; n_spawn = -1; n_sync = -1;
    while (n < 100 && n_spawn < 0) begin
      cyc(1'b0, 1'b1, 1'b0);
      n++;
      if (n_sync < 0 && as) n_sync = n;
      if (a0 != 0) n_spawn = n;
    end
  endtask

  task automatic wait_sync();
    int n;
    n = 0;
    while (!as && n < 50) begin
      cyc(1'b0, 1'b1, 1'b0);
      n++;
    end
    chk("sync_wait", int'(as), 1);
  endtask

  initial begin
    int ns, nsy;
    for (int d = 0; d < 2; d++) m_init(d);
    repeat (3) cyc(1'b1, 1'b1, 1'b0);

    // after release: sync rises in the 5th cycle (4 edges), first spawn
    // becomes visible after the 2nd tick's SPAWN (18 edges)
    edges_to_spawn(ns, nsy);
    chk("first_sync_edge", nsy, 4);
    chk("first_spawn_edge", ns, 18);

    // freeze mid-UPD: sequence finishes, then 100 frozen cycles
    wait_sync();
    cyc(1'b0, 1'b1, 1'b0);
    repeat (100) cyc(1'b0, 1'b0, 1'b0);

    // long run with occasional freezes; d1 fills all four slots
    for (int i = 0; i < 3200; i++)
      cyc(1'b0, ($urandom_range(0, 19) != 0), 1'b0);
    chk("d1_full_seen", int'(full_seen), 1);

    // clear during the 2nd UPD cycle, then replay must match post-reset
    wait_sync();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("clr_sync", int'(as), 0);
    chk("clr_slot0", int'(a0), 0);
    chk("clr_d1_slot3", int'(b3), 0);
    edges_to_spawn(ns, nsy);
    chk("replay_sync_edge", nsy, 4);
    chk("replay_spawn_edge", ns, 18);

    // random run/clear traffic
    for (int i = 0; i < 2500; i++)
      cyc(1'b0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 299) == 0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
